// File: rtl/operand2_stage.sv
// operand2_stage: registered operand-2 source select for the MIPS datapath.
// Picks PB, HI, LO, PC, or an immediate form, and drives the result through a
// valid/ready output register. A HI/LO read made while mult/div is busy waits
// here until a write-back forward arrives or the wait budget runs out.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready, sel     request handshake and source select
//   PB, HI, LO, PC, imm        candidate operand sources
//   hilo_busy                  HI/LO result still outstanding
//   hi_wr_*, lo_wr_*           same-cycle HI/LO write-back forward
//   out_valid/out_ready, N     result handshake and selected operand
//   out_sel                    select that produced N
//   timeout_err, stall_cnt     debug: sticky wait timeout, saturating WAIT count
module operand2_stage #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned IMM_W       = 16,
    parameter int unsigned PC_INC      = 8,
    parameter int unsigned MAX_WAIT    = 64,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             sel,
    input  logic [DATA_W-1:0]      PB,
    input  logic [DATA_W-1:0]      HI,
    input  logic [DATA_W-1:0]      LO,
    input  logic [DATA_W-1:0]      PC,
    input  logic [IMM_W-1:0]       imm,
    input  logic                   hilo_busy,
    input  logic                   hi_wr_en,
    input  logic [DATA_W-1:0]      hi_wr_data,
    input  logic                   lo_wr_en,
    input  logic [DATA_W-1:0]      lo_wr_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      N,
    output logic [2:0]             out_sel,
    output logic                   timeout_err,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int unsigned LUI_SH = DATA_W - IMM_W;

    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [2:0]             r_sel;
    logic [WAIT_W-1:0]      r_wait_cnt;
    logic                   r_out_valid;
    logic [DATA_W-1:0]      r_n;
    logic [2:0]             r_out_sel;
    logic                   r_timeout_err;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic [2:0]             w_sel_eff;
    logic [DATA_W-1:0]      w_hi_eff;
    logic [DATA_W-1:0]      w_lo_eff;
    logic [DATA_W-1:0]      w_operand;
    logic                   w_blocked;
    logic                   w_out_free;
    logic                   w_wait_expired;
    logic                   w_load;
    logic                   w_load_zero;
    logic                   w_enter_wait;

    // In WAIT the latched select drives decode; in RUN the live request does.
    assign w_sel_eff = (r_state == ST_WAIT) ? r_sel : sel;
    assign w_hi_eff  = hi_wr_en ? hi_wr_data : HI;
    assign w_lo_eff  = lo_wr_en ? lo_wr_data : LO;

    // A HI/LO read blocks only if busy and no forward of that register this cycle.
    always_comb begin
        w_blocked = 1'b0;
        if (w_sel_eff == 3'b001) w_blocked = hilo_busy && !hi_wr_en;
        if (w_sel_eff == 3'b010) w_blocked = hilo_busy && !lo_wr_en;
    end

    // Source select decode.
    always_comb begin
        w_operand = '0;
        case (w_sel_eff)
            3'b000:  w_operand = PB;
            3'b001:  w_operand = w_hi_eff;
            3'b010:  w_operand = w_lo_eff;
            3'b011:  w_operand = PC;
            3'b100:  w_operand = DATA_W'($signed(imm));
            3'b101:  w_operand = DATA_W'(imm);
            3'b110:  w_operand = DATA_W'(imm) << LUI_SH;
            3'b111:  w_operand = PC + DATA_W'(PC_INC);
            default: w_operand = '0;
        endcase
    end

    assign w_out_free     = !r_out_valid || out_ready;
    assign in_ready       = (r_state == ST_RUN) && w_out_free;
    // Current WAIT cycle is the MAX_WAIT-th one.
    assign w_wait_expired = (r_wait_cnt >= WAIT_W'(MAX_WAIT - 1));

    // Next-state and load decisions.
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_load_zero  = 1'b0;
        w_enter_wait = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (in_valid && in_ready) begin
                    if (w_blocked) begin
                        w_enter_wait = 1'b1;
                        w_state_nxt  = ST_WAIT;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (w_out_free) begin
                    if (!w_blocked) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else if (w_wait_expired) begin
                        w_load_zero = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // State, output register and debug counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_sel         <= '0;
            r_wait_cnt    <= '0;
            r_out_valid   <= 1'b0;
            r_n           <= '0;
            r_out_sel     <= '0;
            r_timeout_err <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_enter_wait) r_sel <= sel;

            if (w_enter_wait)
                r_wait_cnt <= '0;
            else if (r_state == ST_WAIT && !w_wait_expired)
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);

            if (r_state == ST_WAIT && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_n         <= w_operand;
                r_out_sel   <= w_sel_eff;
            end else if (w_load_zero) begin
                r_out_valid   <= 1'b1;
                r_n           <= '0;
                r_out_sel     <= r_sel;
                r_timeout_err <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign N           = r_n;
    assign out_sel     = r_out_sel;
    assign timeout_err = r_timeout_err;
    assign stall_cnt   = r_stall_cnt;

endmodule
